conv_pack_buffer: RTL

CONV_PACK_BUFFER -- requirements
Module: conv_pack_buffer

---
 rtl/conv_pack_pkg.sv | 20 ++
 rtl/elem_relu.sv | 13 +
 rtl/conv_pack_buffer.sv | 83 ++++++++
 3 files changed

// File: rtl/conv_pack_pkg.sv
// conv_pack_pkg: frame geometry constants and state type shared by the conv pack buffer.
package conv_pack_pkg;

    localparam int CONV_W = 6;
    localparam int CONV_H = 6;
    localparam int CONV_D = 3;
    localparam int ELEM_W = 8;
    localparam int N_ELEM = CONV_W * CONV_H * CONV_D;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    // Linear position of element (channel d, row r, column c) in a raster-ordered frame.
    function automatic int elem_index(input int d, input int r, input int c);
        return d * CONV_W * CONV_H + r * CONV_W + c;
    endfunction

endpackage

// File: rtl/elem_relu.sv
// elem_relu: combinational ReLU on one signed element; negative values become zero.
module elem_relu #(
    parameter int DW = 8
) (
    input  logic [DW-1:0] in_data,
    output logic [DW-1:0] out_data
);

    always_comb begin
        out_data = in_data[DW-1] ? '0 : in_data;
    end

endmodule

// File: rtl/conv_pack_buffer.sv
// conv_pack_buffer: packs a raster-ordered stream of conv elements into one frame vector.
// Define CONV_PACK_RELU_EN to clamp negative elements to zero as they are stored.
module conv_pack_buffer
    import conv_pack_pkg::*;
#(
    parameter int DW     = ELEM_W,
    parameter int N_ELEM = CONV_W * CONV_H * CONV_D
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DW-1:0]        in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N_ELEM*DW-1:0] conv_lin,
    output logic                 frame_err
);

    localparam int             IW       = $clog2(N_ELEM);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_ELEM - 1);

    state_t                 state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [N_ELEM*DW-1:0]   lin_q, lin_d;
    logic                   err_q, err_d;
    logic [DW-1:0]          elem;
    logic                   accept;

`ifdef CONV_PACK_RELU_EN
    elem_relu #(.DW(DW)) u_relu (
        .in_data (in_data),
        .out_data(elem)
    );
`else
    assign elem = in_data;
`endif

    // Acceptance and handoff are mutually exclusive because they live in different states.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        lin_d   = lin_q;
        err_d   = 1'b0;
        accept  = in_valid && (state_q == FILL);
        if (accept) begin
            lin_d[idx_q*DW +: DW] = elem;
            if (idx_q == LAST_IDX) begin
                idx_d   = '0;
                state_d = FULL;
                err_d   = !in_last;
            end else if (in_last) begin
                idx_d = '0;
                err_d = 1'b1;
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end else if (state_q == FULL && out_ready) begin
            state_d = FILL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            idx_q   <= '0;
            lin_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lin_q   <= lin_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = (state_q == FILL);
    assign out_valid = (state_q == FULL);
    assign conv_lin  = lin_q;
    assign frame_err = err_q;

endmodule
